branch_resolve_unit: RTL

- Parametrised branch resolution and prediction block for the core's execute stage.
- Evaluates conditional branches (branch_op_e) on XLEN-wide operands and computes the target and fall-through redirect PC.
- Registers the result one cycle later.
- Trains an internal direct-mapped table of 2-bit saturating counters (BHT) that fetch reads combinationally for predictions.

---
 rtl/branch_resolve_unit.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// Branch resolution with a 1-cycle registered result and a 2-bit counter BHT for fetch prediction.
// Optional BRANCH_STATS_EN adds resolved-branch and mispredict counters.
module branch_resolve_unit #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned BHT_ENTRIES = 64,
   parameter logic [1:0]  BHT_RESET   = 2'b01
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [XLEN-1:0] pred_pc_i,
   output logic            pred_taken_o,
   input  logic            res_valid_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic [XLEN-1:0] rs2_data_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] imm_i,
   input  logic            pred_taken_i,
   input  logic            flush_i,
   output logic            res_valid_o,
   output logic            taken_o,
   output logic [XLEN-1:0] target_o,
   output logic [XLEN-1:0] redirect_pc_o,
   output logic            mispredict_o
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0]     stat_branches_o,
   output logic [31:0]     stat_mispred_o
`endif
);

   localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

   localparam logic [2:0] OP_BEQ  = 3'd0;
   localparam logic [2:0] OP_BNE  = 3'd1;
   localparam logic [2:0] OP_BLT  = 3'd4;
   localparam logic [2:0] OP_BGE  = 3'd5;
   localparam logic [2:0] OP_BLTU = 3'd6;
   localparam logic [2:0] OP_BGEU = 3'd7;

   logic [1:0]      r_bht [BHT_ENTRIES];

   logic            r_valid;
   logic            r_taken;
   logic [XLEN-1:0] r_target;
   logic [XLEN-1:0] r_redirect;
   logic            r_mispred;

   logic [IDX_W-1:0] w_pred_idx;
   logic [IDX_W-1:0] w_res_idx;
   logic             w_eq;
   logic             w_lt;
   logic             w_ltu;
   logic             w_taken;
   logic             w_op_valid;
   logic             w_accept;
   logic [XLEN-1:0]  w_target;
   logic [XLEN-1:0]  w_fall;
   logic [1:0]       w_ctr;
   logic [1:0]       w_ctr_next;
   logic             w_unused;

   // Index drops the byte-offset bits; upper PC bits alias into the table.
   assign w_pred_idx = pred_pc_i[IDX_W+1:2];
   assign w_res_idx  = pc_i[IDX_W+1:2];
   assign w_unused   = ^{pred_pc_i, pc_i};

   assign pred_taken_o = r_bht[w_pred_idx][1];

   assign w_eq     = (rs1_data_i == rs2_data_i);
   assign w_lt     = ($signed(rs1_data_i) < $signed(rs2_data_i));
   assign w_ltu    = (rs1_data_i < rs2_data_i);
   assign w_target = pc_i + imm_i;
   assign w_fall   = pc_i + XLEN'(4);
   assign w_accept = res_valid_i & ~flush_i;

   // Direction decode; unknown encodings resolve not-taken and skip training.
   always_comb begin
      w_taken    = 1'b0;
      w_op_valid = 1'b1;
      case (op_i)
         OP_BEQ:  w_taken = w_eq;
         OP_BNE:  w_taken = ~w_eq;
         OP_BLT:  w_taken = w_lt;
         OP_BGE:  w_taken = ~w_lt;
         OP_BLTU: w_taken = w_ltu;
         OP_BGEU: w_taken = ~w_ltu;
         default: w_op_valid = 1'b0;
      endcase
   end

   // Saturating counter step for the entry being trained.
   always_comb begin
      w_ctr      = r_bht[w_res_idx];
      w_ctr_next = w_ctr;
      if (w_taken) begin
         if (w_ctr != 2'b11) w_ctr_next = w_ctr + 2'd1;
      end else begin
         if (w_ctr != 2'b00) w_ctr_next = w_ctr - 2'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(BHT_ENTRIES); i++) r_bht[i] <= BHT_RESET;
      end else if (w_accept && w_op_valid) begin
         r_bht[w_res_idx] <= w_ctr_next;
      end
   end

   // Result register; data fields hold while no new result is accepted.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_valid    <= 1'b0;
         r_taken    <= 1'b0;
         r_target   <= '0;
         r_redirect <= '0;
         r_mispred  <= 1'b0;
      end else begin
         r_valid   <= w_accept;
         r_mispred <= w_accept & (w_taken != pred_taken_i);
         if (w_accept) begin
            r_taken    <= w_taken;
            r_target   <= w_target;
            r_redirect <= w_taken ? w_target : w_fall;
         end
      end
   end

   assign res_valid_o   = r_valid;
   assign taken_o       = r_taken;
   assign target_o      = r_target;
   assign redirect_pc_o = r_redirect;
   assign mispredict_o  = r_mispred;

`ifdef BRANCH_STATS_EN
   logic [31:0] r_stat_br;
   logic [31:0] r_stat_mis;

   // Counts each presented result once, on the edge it is sampled.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_stat_br  <= '0;
         r_stat_mis <= '0;
      end else begin
         if (r_valid)   r_stat_br  <= r_stat_br + 32'd1;
         if (r_mispred) r_stat_mis <= r_stat_mis + 32'd1;
      end
   end

   assign stat_branches_o = r_stat_br;
   assign stat_mispred_o  = r_stat_mis;
`endif

endmodule
